// File: rtl/csa_calc_sched.sv
// CSA calc scheduler: fetches input words, dispatches them round-robin to N calc
// instances, retires results in dispatch order. Optional watchdog: CSA_SCHED_TIMEOUT_EN.

module csa_calc_slot #(
  parameter int IW             = 40,
  parameter int OW             = 48,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic [IW-1:0] i_op,
  input  logic          i_done,
  input  logic [OW-1:0] i_res,
  input  logic          i_retire,
  input  logic          i_clear,
  output logic          o_free,
  output logic          o_held,
  output logic [IW-1:0] o_op,
  output logic [OW-1:0] o_res,
  output logic          o_tmo
);
  typedef enum logic [1:0] {S_FREE, S_BUSY, S_HELD} slot_t;

  slot_t         r_st;
  logic [IW-1:0] r_op;
  logic [OW-1:0] r_res;
  logic          w_expire;

`ifdef CSA_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  logic          r_tmo;

  // Expires on the TIMEOUT_CYCLES-th BUSY cycle; a done in that cycle still wins.
  assign w_expire = (r_st == S_BUSY) && !i_done && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_tmo <= 1'b0;
    end else begin
      r_cnt <= (r_st == S_BUSY) ? r_cnt + CW'(1) : '0;
      if (w_expire)     r_tmo <= 1'b1;
      else if (i_clear) r_tmo <= 1'b0;
    end
  end
  assign o_tmo = r_tmo;
`else
  logic w_unused_clear;
  assign w_unused_clear = i_clear;
  assign w_expire       = 1'b0;
  assign o_tmo          = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st  <= S_FREE;
      r_op  <= '0;
      r_res <= '0;
    end else begin
      case (r_st)
        S_FREE: if (i_start) begin
          r_st <= S_BUSY;
          r_op <= i_op;
        end
        S_BUSY: if (i_done) begin
          r_st  <= S_HELD;
          r_res <= i_res;
        end else if (w_expire) begin
          r_st  <= S_HELD;
          r_res <= '0;
        end
        S_HELD: if (i_retire) r_st <= S_FREE;
        default: r_st <= S_FREE;
      endcase
    end
  end

  assign o_free = (r_st == S_FREE);
  assign o_held = (r_st == S_HELD);
  assign o_op   = r_op;
  assign o_res  = r_res;
endmodule

module csa_calc_sched #(
  parameter int CSA_CALC_INST_NUM  = 4,
  parameter int CSA_CALC_IN_WIDTH  = 40,
  parameter int CSA_CALC_OUT_WIDTH = 48,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                                          csa_calc_clk,
  input  logic                                          rst_n,
  input  logic                                          cfg_enable,
  input  logic                                          csa_in_r_ready,
  output logic                                          csa_in_ren,
  input  logic [CSA_CALC_IN_WIDTH-1:0]                  csa_in_rdata,
  output logic [CSA_CALC_INST_NUM-1:0]                  calc_start,
  output logic [CSA_CALC_INST_NUM*CSA_CALC_IN_WIDTH-1:0]  calc_in_data,
  input  logic [CSA_CALC_INST_NUM-1:0]                  calc_done,
  input  logic [CSA_CALC_INST_NUM*CSA_CALC_OUT_WIDTH-1:0] calc_out_data,
  input  logic                                          csa_out_error_full,
  output logic                                          csa_out_wen,
  output logic [CSA_CALC_OUT_WIDTH-1:0]                 csa_out_wdata,
  output logic                                          sched_busy,
  output logic [31:0]                                   dispatch_count,
  output logic [31:0]                                   retire_count,
  output logic [CSA_CALC_INST_NUM-1:0]                  timeout_flags,
  input  logic                                          clear_flags
);
  localparam int N  = CSA_CALC_INST_NUM;
  localparam int IW = CSA_CALC_IN_WIDTH;
  localparam int OW = CSA_CALC_OUT_WIDTH;
  localparam int PW = $clog2(N);

  typedef enum logic [1:0] {F_IDLE, F_WAIT, F_ISSUE} fetch_t;

  fetch_t                 r_fst, w_fst_nxt;
  logic [PW-1:0]          r_disp_ptr, r_ret_ptr;
  logic [31:0]            r_disp_cnt, r_ret_cnt;
  logic                   r_ren;
  logic [N-1:0]           r_start;
  logic [N-1:0]           w_free, w_held, w_issue, w_retire;
  logic [N-1:0][IW-1:0]   w_op;
  logic [N-1:0][OW-1:0]   w_res, w_cres;
  logic                   w_fetch_go, w_retire_go;

  assign w_cres = calc_out_data;

  // Positional round-robin: stall on a non-FREE slot so retire order matches dispatch order.
  assign w_fetch_go  = (r_fst == F_IDLE) && cfg_enable && csa_in_r_ready && w_free[r_disp_ptr];
  assign w_retire_go = w_held[r_ret_ptr] && !csa_out_error_full;

  always_comb begin
    w_fst_nxt = r_fst;
    case (r_fst)
      F_IDLE:  if (w_fetch_go) w_fst_nxt = F_WAIT;
      F_WAIT:  w_fst_nxt = F_ISSUE;
      F_ISSUE: w_fst_nxt = F_IDLE;
      default: w_fst_nxt = F_IDLE;
    endcase
  end

  always_ff @(posedge csa_calc_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fst      <= F_IDLE;
      r_ren      <= 1'b0;
      r_start    <= '0;
      r_disp_ptr <= '0;
      r_disp_cnt <= '0;
      r_ret_ptr  <= '0;
      r_ret_cnt  <= '0;
    end else begin
      r_fst   <= w_fst_nxt;
      r_ren   <= w_fetch_go;
      r_start <= w_issue;
      if (r_fst == F_ISSUE) begin
        r_disp_ptr <= r_disp_ptr + PW'(1);
        r_disp_cnt <= r_disp_cnt + 32'd1;
      end
      if (w_retire_go) begin
        r_ret_ptr <= r_ret_ptr + PW'(1);
        r_ret_cnt <= r_ret_cnt + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_slot
    assign w_issue[g]  = (r_fst == F_ISSUE) && (r_disp_ptr == PW'(g));
    assign w_retire[g] = w_retire_go && (r_ret_ptr == PW'(g));

    csa_calc_slot #(.IW(IW), .OW(OW), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_slot (
      .clk      (csa_calc_clk),
      .rst_n    (rst_n),
      .i_start  (w_issue[g]),
      .i_op     (csa_in_rdata),
      .i_done   (calc_done[g]),
      .i_res    (w_cres[g]),
      .i_retire (w_retire[g]),
      .i_clear  (clear_flags),
      .o_free   (w_free[g]),
      .o_held   (w_held[g]),
      .o_op     (w_op[g]),
      .o_res    (w_res[g]),
      .o_tmo    (timeout_flags[g])
    );
  end

  assign csa_in_ren     = r_ren;
  assign calc_start     = r_start;
  assign calc_in_data   = w_op;
  assign csa_out_wen    = w_retire_go;
  assign csa_out_wdata  = w_res[r_ret_ptr];
  assign sched_busy     = (r_fst != F_IDLE) || !(&w_free);
  assign dispatch_count = r_disp_cnt;
  assign retire_count   = r_ret_cnt;
endmodule

// File: tb/tb_csa_calc_sched.sv
// Directed bench for csa_calc_sched: FIFO + instance models, scoreboard of expected
// results derived from the pushed words, plus literal checkpoints.
module tb_csa_calc_sched;
  localparam int N  = 4;
  localparam int IW = 40;
  localparam int OW = 48;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_enable = 1'b0;
  logic              csa_in_r_ready, csa_in_ren;
  logic [IW-1:0]     csa_in_rdata;
  logic [N-1:0]      calc_start;
  logic [N*IW-1:0]   calc_in_data;
  logic [N-1:0]      calc_done = '0;
  logic [N*OW-1:0]   calc_out_data = '0;
  logic              full = 1'b0;
  logic              wen;
  logic [OW-1:0]     wdata;
  logic              busy;
  logic [31:0]       dcnt, rcnt;
  logic [N-1:0]      tflags;
  logic              clear_flags = 1'b0;

  csa_calc_sched #(.CSA_CALC_INST_NUM(N), .CSA_CALC_IN_WIDTH(IW),
                   .CSA_CALC_OUT_WIDTH(OW), .TIMEOUT_CYCLES(16)) dut (
    .csa_calc_clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable),
    .csa_in_r_ready(csa_in_r_ready), .csa_in_ren(csa_in_ren), .csa_in_rdata(csa_in_rdata),
    .calc_start(calc_start), .calc_in_data(calc_in_data), .calc_done(calc_done),
    .calc_out_data(calc_out_data), .csa_out_error_full(full), .csa_out_wen(wen),
    .csa_out_wdata(wdata), .sched_busy(busy), .dispatch_count(dcnt), .retire_count(rcnt),
    .timeout_flags(tflags), .clear_flags(clear_flags));

  always #5 clk = ~clk;

  int nchk = 0, nfail = 0;
  logic [IW-1:0] in_mem [0:63];
  logic [OW-1:0] exp_mem[0:63];
  logic [OW-1:0] out_log[0:63];
  int wr_idx = 0, rd_idx = 0;
  int disp_k = 0, out_k = 0, ren_n = 0;
  int lat[N];
  bit hang[N];
  int rem[N];
  bit ibusy[N];
  logic [IW-1:0] iop[N];

  function automatic logic [OW-1:0] f(input logic [IW-1:0] w);
    return {8'hC3, w};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [IW-1:0] w);
    in_mem[wr_idx] = w;
    wr_idx++;
  endtask

  task automatic wait_ret(input int tgt, input string nm);
    int c = 0;
    while (rcnt != tgt && c < 3000) begin @(posedge clk); #1; c++; end
    chk(nm, rcnt, tgt);
  endtask

  task automatic wait_idle(input string nm);
    int c = 0;
    repeat (2) @(posedge clk);
    #1;
    while (busy && c < 3000) begin @(posedge clk); #1; c++; end
    chk(nm, busy, 0);
  endtask

  // Input FIFO: data appears the cycle after the read strobe.
  assign csa_in_r_ready = (rd_idx != wr_idx);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx       <= 0;
      csa_in_rdata <= '0;
    end else if (csa_in_ren && rd_idx != wr_idx) begin
      csa_in_rdata <= in_mem[rd_idx];
      rd_idx       <= rd_idx + 1;
    end
  end

  // Calc instance models: fixed latency per instance, result = f(operand), optional hang.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      calc_done[i] = 1'b0;
      if (ibusy[i]) begin
        if (rem[i] <= 1) begin
          ibusy[i] = 1'b0;
          if (!hang[i]) begin
            calc_done[i] = 1'b1;
            calc_out_data[i*OW +: OW] = f(iop[i]);
          end
        end else rem[i]--;
      end
      if (calc_start[i]) begin
        ibusy[i] = 1'b1;
        rem[i]   = lat[i];
        iop[i]   = calc_in_data[i*IW +: IW];
      end
    end
  end

  // Scoreboard: k-th dispatch goes to slot k mod N with the k-th FIFO word; outputs in that order.
  always @(negedge clk) begin
    int idx;
    if (!rst_n) begin
      disp_k = 0;
      out_k  = 0;
    end else begin
      if (calc_start != '0) begin
        idx = disp_k % N;
        chk("start_slot", 64'(calc_start), 64'(1) << idx);
        chk("start_operand", 64'(calc_in_data[idx*IW +: IW]), 64'(in_mem[disp_k]));
        exp_mem[disp_k] = hang[idx] ? '0 : f(in_mem[disp_k]);
        disp_k++;
      end
      if (csa_in_ren) ren_n++;
      if (wen) begin
        chk("wen_while_full", 64'(full), 0);
        chk("out_word", 64'(wdata), (out_k < disp_k) ? 64'(exp_mem[out_k]) : 64'hDEAD);
        out_log[out_k] = wdata;
        out_k++;
      end
`ifndef CSA_SCHED_TIMEOUT_EN
      chk("tflags_zero", 64'(tflags), 0);
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0, c;
    for (int i = 0; i < N; i++) begin lat[i] = 10; hang[i] = 1'b0; end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wen", wen, 0);
    chk("rst_ren", csa_in_ren, 0);
    chk("rst_start", 64'(calc_start), 0);
    chk("rst_busy", busy, 0);
    chk("rst_dcnt", dcnt, 0);
    chk("rst_rcnt", rcnt, 0);
    chk("rst_opnd", 64'(calc_in_data != '0), 0);
    rst_n = 1'b1;

    // 8 words, latency 10
    for (int k = 0; k < 8; k++) push(40'(k));
    cfg_enable = 1'b1;
    wait_ret(8, "t1_retire");
    wait_idle("t1_idle");
    chk("t1_dcnt", dcnt, 8);
    chk("t1_outk", out_k, 8);
    chk("t1_out0", out_log[0], 48'hC3_0000000000);
    chk("t1_out7", out_log[7], 48'hC3_0000000007);

    // slow instance 0 holds back the others
    lat[0] = 20; lat[1] = 5; lat[2] = 5; lat[3] = 5;
    for (int k = 0; k < 4; k++) push(40'hAB00000000 | 40'(k));
    wait_ret(12, "t2_retire");
    wait_idle("t2_idle");
    chk("t2_out8", out_log[8], 48'hC3_AB00000000);
    chk("t2_out11", out_log[11], 48'hC3_AB00000003);

    // output FIFO full
    for (int i = 0; i < N; i++) lat[i] = 5;
    full = 1'b1;
    for (int k = 0; k < 6; k++) push(40'hF000000000 | 40'(k));
    repeat (100) @(posedge clk);
    #1;
    chk("t3_dcnt_full", dcnt, 16);
    chk("t3_ren_stop", csa_in_ren, 0);
    chk("t3_rcnt_full", rcnt, 12);
    full = 1'b0;
    wait_ret(18, "t3_retire");
    wait_idle("t3_idle");
    chk("t3_dcnt", dcnt, 18);
    chk("t3_out17", out_log[17], 48'hC3_F000000005);

    // enable dropped right after a read
    cfg_enable = 1'b0;
    push(40'h4400000000);
    push(40'h4400000001);
    r0 = ren_n;
    cfg_enable = 1'b1;
    c = 0;
    while (!csa_in_ren && c < 50) begin @(posedge clk); #1; c++; end
    chk("t4_ren_seen", csa_in_ren, 1);
    @(posedge clk);
    #1 cfg_enable = 1'b0;
    wait_ret(19, "t4_retire");
    repeat (20) @(posedge clk);
    #1;
    chk("t4_ren_once", ren_n - r0, 1);
    chk("t4_dcnt", dcnt, 19);
    chk("t4_busy", busy, 0);
    chk("t4_left", wr_idx - rd_idx, 1);
    chk("t4_out18", out_log[18], 48'hC3_4400000000);

    // async reset with instances busy
    for (int i = 0; i < N; i++) lat[i] = 30;
    push(40'h5500000000);
    push(40'h5500000001);
    cfg_enable = 1'b1;
    c = 0;
    while (dcnt != 22 && c < 200) begin @(posedge clk); #1; c++; end
    chk("t5_dcnt_pre", dcnt, 22);
    @(posedge clk);
    #3 rst_n = 1'b0;
    wr_idx = 0;
    #1;
    chk("t5_rst_dcnt", dcnt, 0);
    chk("t5_rst_rcnt", rcnt, 0);
    chk("t5_rst_start", 64'(calc_start), 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_ren", csa_in_ren, 0);
    chk("t5_rst_wen", wen, 0);
    chk("t5_rst_opnd", 64'(calc_in_data != '0), 0);
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    chk("t5_dcnt", dcnt, 0);
    chk("t5_rcnt", rcnt, 0);
    chk("t5_busy", busy, 0);
    chk("t5_outk", out_k, 0);

`ifdef CSA_SCHED_TIMEOUT_EN
    // instance 2 hangs; watchdog substitutes a zero result in order
    for (int i = 0; i < N; i++) lat[i] = 5;
    hang[2] = 1'b1;
    for (int k = 0; k < 4; k++) push(40'h6600000000 | 40'(k));
    wait_ret(4, "t6_retire");
    chk("t6_flags", 64'(tflags), 64'h4);
    chk("t6_out2", out_log[2], 48'h0);
    chk("t6_out3", out_log[3], 48'hC3_6600000003);
    clear_flags = 1'b1;
    @(posedge clk);
    #1 clear_flags = 1'b0;
    chk("t6_cleared", 64'(tflags), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
